// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between the instruction bus master port
// and decode. Issues word reads from a local PC, buffers responses in a small
// FIFO and hands instruction words to decode in program order. Jumps flush
// the FIFO and discard any responses still in flight for the old stream.
// Optional bus-error tracking is compiled in with `define FETCH_BUS_ERR_EN.
module fetch_unit #(
  parameter int FETCH_BUF_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en_i,
  input  logic        jump_i,
  input  logic [31:0] pc_jump_i,
  input  logic [31:0] pc_reset_i,
  output logic        instr_req_valid_o,
  input  logic        instr_req_ready_i,
  output logic [31:0] instr_req_addr_o,
  input  logic        instr_resp_valid_i,
  output logic        instr_resp_ready_o,
  input  logic [31:0] instr_resp_data_i,
  input  logic        instr_resp_err_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_instr_o,
  output logic        fetch_err_o
);
  localparam int AW = $clog2(FETCH_BUF_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 2);

  typedef enum logic [1:0] {IDLE, RUN, HOLD_JUMP} state_t;
`ifdef FETCH_BUS_ERR_EN
  typedef struct packed { logic err; logic [31:0] data; } entry_t;
`else
  typedef struct packed { logic [31:0] data; } entry_t;
`endif

  state_t        state_ff, state_nxt;
  logic [31:0]   pc_ff, jump_pc_ff;
  logic [CW-1:0] out_ff, out_nxt, disc_ff, disc_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  entry_t        mem [FETCH_BUF_DEPTH];
  entry_t        push_entry, head;
  logic          stall_ff, credit_ok, stop, req_valid, hs, stall;
  logic          drop, push, pop, empty;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  // Reserve FIFO space for every read in flight so responses never overflow.
  assign credit_ok = (int'(out_ff) < MAX_OUTSTANDING) &&
                     ((int'(count) + int'(out_ff)) < FETCH_BUF_DEPTH);
  assign hs        = req_valid & instr_req_ready_i;
  assign stall     = req_valid & ~instr_req_ready_i;
  // Responses in the jump cycle, or still owed to the old stream, are dropped.
  assign drop      = jump_i | (disc_ff != '0);
  assign push      = instr_resp_valid_i & ~drop;
  assign pop       = fetch_valid_o & fetch_ready_i;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_nxt   = out_ff + CW'(hs) - CW'(instr_resp_valid_i);

`ifdef FETCH_BUS_ERR_EN
  logic err_stop_ff;
  assign stop        = err_stop_ff;
  assign push_entry  = '{err: instr_resp_err_i, data: instr_resp_data_i};
  assign fetch_err_o = ~empty & head.err;

  // An erroring word parks the fetcher until decode redirects it.
  always_ff @(posedge clk) begin
    if (!rst)                          err_stop_ff <= 1'b0;
    else if (jump_i)                   err_stop_ff <= 1'b0;
    else if (push && instr_resp_err_i) err_stop_ff <= 1'b1;
  end
`else
  logic unused_err;
  assign unused_err  = instr_resp_err_i;
  assign stop        = 1'b0;
  assign push_entry  = '{data: instr_resp_data_i};
  assign fetch_err_o = 1'b0;
`endif

  // State register plus PC, credit and discard bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_ff   <= IDLE;
      pc_ff      <= pc_reset_i;
      jump_pc_ff <= '0;
      out_ff     <= '0;
      disc_ff    <= '0;
      stall_ff   <= 1'b0;
    end else begin
      state_ff <= state_nxt;
      out_ff   <= out_nxt;
      disc_ff  <= disc_nxt;
      stall_ff <= stall;
      if (jump_i && stall) jump_pc_ff <= pc_jump_i;
      if (jump_i && !stall)
        pc_ff <= pc_jump_i;
      else if (hs)
        pc_ff <= (state_ff == HOLD_JUMP) ? jump_pc_ff : pc_ff + 32'd4;
    end
  end

  // Discard count: a jump owes every read in flight; a held old request adds one more on acceptance.
  always_comb begin
    disc_nxt = disc_ff;
    if (jump_i) begin
      disc_nxt = out_nxt;
    end else begin
      if (instr_resp_valid_i && disc_ff != '0) disc_nxt = disc_nxt - CW'(1);
      if (state_ff == HOLD_JUMP && hs)         disc_nxt = disc_nxt + CW'(1);
    end
  end

  // Next state: a stalled request is never withdrawn, so leaving RUN waits for it.
  always_comb begin
    state_nxt = state_ff;
    case (state_ff)
      IDLE:      if (fetch_en_i) state_nxt = RUN;
      RUN: begin
        if (jump_i && stall)            state_nxt = HOLD_JUMP;
        else if (!fetch_en_i && !stall) state_nxt = IDLE;
      end
      HOLD_JUMP: if (hs) state_nxt = fetch_en_i ? RUN : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs: request valid per state; decode sees the FIFO head unless a jump flushes it.
  always_comb begin
    req_valid = 1'b0;
    case (state_ff)
      RUN:       req_valid = stall_ff | (credit_ok & ~stop);
      HOLD_JUMP: req_valid = 1'b1;
      default:   req_valid = 1'b0;
    endcase
  end

  assign instr_req_valid_o  = req_valid;
  assign instr_req_addr_o   = pc_ff;
  assign instr_resp_ready_o = 1'b1;
  assign fetch_valid_o      = ~empty & ~jump_i;
  assign fetch_instr_o      = empty ? '0 : head.data;

  // FIFO pointers; a jump empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst || jump_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage, no reset needed: contents are only read when non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end
endmodule
